branch_resolve: RTL

//  Consumes the eq/gt/lt flags produced by the 16-bit magnitude comparator (comp) and resolves conditional branches.

---
 rtl/branch_resolve.sv | 97 +++++++++
 1 files changed

// File: rtl/branch_resolve.sv
// branch_resolve: resolves conditional branches from comparator flags; optional BRU_STATS_EN adds branch/taken counters
module branch_resolve #(
  parameter int N      = 16,
  parameter int PC_INC = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [2:0]   req_op,
  input  logic [N-1:0] req_pc,
  input  logic [N-1:0] req_offset,
  input  logic         rs1_msb,
  input  logic         rs2_msb,
  input  logic         cmp_eq,
  input  logic         cmp_gt,
  input  logic         cmp_lt,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_taken,
  output logic [N-1:0] rsp_target,
`ifdef BRU_STATS_EN
  output logic [15:0]  stat_branches,
  output logic [15:0]  stat_taken,
`endif
  output logic         rsp_err
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t         state_q;
  logic [2:0]     op_q;
  logic [N-1:0]   pc_q, off_q;
  logic           m1_q, m2_q, eq_q, gt_q, lt_q;
  logic           slt, base, cond, err_d, rsp_taken_d;
  logic [N-1:0]   rsp_target_d;
  assign req_ready = (state_q == IDLE) & ~flush & ~rst;
  // condition and target from the captured request; signed compare fixed up from operand sign bits
  always_comb begin
    slt          = (m1_q != m2_q) ? m1_q : lt_q;
    base         = op_q[1] ? lt_q : slt;
    cond         = op_q[2] ? (base ^ op_q[0]) : (eq_q ^ op_q[0]);
    err_d        = (op_q[2:1] == 2'b01) | ~$onehot({eq_q, gt_q, lt_q});
    rsp_taken_d  = cond & ~err_d;
    rsp_target_d = pc_q + (rsp_taken_d ? off_q : N'(PC_INC));
  end
  // request FSM: capture on accept, resolve in EXEC, hold response in DONE until consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rsp_valid  <= 1'b0;
      rsp_taken  <= 1'b0;
      rsp_target <= '0;
      rsp_err    <= 1'b0;
    end else if (flush) begin
      state_q   <= IDLE;
      rsp_valid <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          state_q <= EXEC;
          op_q    <= req_op;
          pc_q    <= req_pc;
          off_q   <= req_offset;
          m1_q    <= rs1_msb;
          m2_q    <= rs2_msb;
          eq_q    <= cmp_eq;
          gt_q    <= cmp_gt;
          lt_q    <= cmp_lt;
        end
        EXEC: begin
          state_q    <= DONE;
          rsp_valid  <= 1'b1;
          rsp_taken  <= rsp_taken_d;
          rsp_target <= rsp_target_d;
          rsp_err    <= err_d;
        end
        DONE: if (rsp_ready) begin
          state_q   <= IDLE;
          rsp_valid <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`ifdef BRU_STATS_EN
  // saturating counters of consumed responses; flushed branches never reach a transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches <= '0;
      stat_taken    <= '0;
    end else if (state_q == DONE && rsp_ready && !flush) begin
      if (stat_branches != 16'hFFFF) stat_branches <= stat_branches + 16'd1;
      if (rsp_taken && stat_taken != 16'hFFFF) stat_taken <= stat_taken + 16'd1;
    end
  end
`endif
endmodule
